pwm_capture: RTL

- PWM receiver: measures period and high time of an external PWM waveform, in clk cycles.
- Companion to the team's PWM generator; used for loopback checking and for reading external PWM sources.
- Publishes one period/high_time pair per completed PWM cycle, with a one-cycle valid strobe.

---
 rtl/pwm_capture.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of pwm_in in clk cycles.
// Optional glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int CNT_BITS   = 16,
  parameter int FILTER_LEN = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                pwm_in,
  input  logic                clear_ovf,
  output logic [CNT_BITS-1:0] period,
  output logic [CNT_BITS-1:0] high_time,
  output logic                valid,
  output logic                overflow
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, HIGH, LOW} state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_filter_len_check
    $error("pwm_capture: FILTER_LEN must be in 1..15");
  end

  logic sync1_q, sync2_q, prev_q;
  logic level;
  logic rise, fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam logic [3:0] RUN_LAST = 4'(FILTER_LEN - 1);

  logic       filt_q, filt_d;
  logic [3:0] run_q, run_d;

  // Level follows the synchronizer only after FILTER_LEN stable cycles.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == RUN_LAST) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_BITS-1:0] period_q, period_d;
  logic [CNT_BITS-1:0] high_time_q, high_time_d;
  logic                valid_q, valid_d;
  logic                overflow_q, overflow_d;
  logic                ovf_set;
  logic [CNT_BITS-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cnt_d    = hi_cnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    ovf_set     = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_EDGE;
          cnt_d   = '0;
        end
        WAIT_EDGE: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        HIGH: begin
          // Saturation discards the partial measurement and re-arms.
          if (cnt_q == CNT_MAX) begin
            ovf_set = 1'b1;
            state_d = WAIT_EDGE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (fall) begin
              hi_cnt_d = cnt_q;
              state_d  = LOW;
            end
          end
        end
        LOW: begin
          if (cnt_q == CNT_MAX) begin
            ovf_set = 1'b1;
            state_d = WAIT_EDGE;
            cnt_d   = '0;
          end else if (rise) begin
            period_d    = cnt_q;
            high_time_d = hi_cnt_q;
            valid_d     = 1'b1;
            state_d     = HIGH;
            cnt_d       = CNT_ONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    overflow_d = ovf_set | (overflow_q & ~clear_ovf);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_cnt_q    <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign overflow  = overflow_q;

endmodule
